// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined execute ALU: funct3 encodings, FSM states
// and operand-signedness helpers for the M-extension group.
package alu_pkg;

    localparam logic [2:0] F3_ADD    = 3'd0;
    localparam logic [2:0] F3_SLL    = 3'd1;
    localparam logic [2:0] F3_SLT    = 3'd2;
    localparam logic [2:0] F3_SLTU   = 3'd3;
    localparam logic [2:0] F3_XOR    = 3'd4;
    localparam logic [2:0] F3_SRL    = 3'd5;
    localparam logic [2:0] F3_OR     = 3'd6;
    localparam logic [2:0] F3_AND    = 3'd7;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} alu_state_t;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic is_rem(input logic [2:0] f3);
        return f3[2] & f3[1];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Shared iterative multiply/divide datapath: one shift-add or restoring-divide
// step per cycle on unsigned magnitudes, with sign correction applied at fix.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            step,
    input  logic            fix,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] d1,
    input  logic [XLEN-1:0] d2,
    output logic            last,
    output logic [XLEN-1:0] result
);
    localparam int CNT_W = $clog2(XLEN);

    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_step;
    logic [XLEN-1:0]   opnd;
    logic [CNT_W-1:0]  count;
    logic [2:0]        op;
    logic              neg_q;
    logic              neg_r;

    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;

    // acc holds {high, low}: multiplier in low half for MUL*, dividend/quotient for DIV*.
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that skips an assignment would infer a latch.
        acc_step  = acc;
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_trial = div_shift - {1'b0, opnd};
        if (is_div(op)) begin
            if (!div_trial[XLEN])
                acc_step = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
                acc_step = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc[XLEN-1:1]};
        end
    end

    always_comb begin
        a_neg = is_signed_a(funct3) && d1[XLEN-1];
        b_neg = is_signed_b(funct3) && d2[XLEN-1];
        a_mag = a_neg ? -d1 : d1;
        b_mag = b_neg ? -d2 : d2;
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            acc   <= '0;
            opnd  <= '0;
            count <= '0;
            op    <= F3_MUL;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (start) begin
            acc   <= is_div(funct3) ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
            opnd  <= is_div(funct3) ? b_mag : a_mag;
            count <= CNT_W'(XLEN - 1);
            op    <= funct3;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
        end else if (step) begin
            acc   <= acc_step;
            count <= count - CNT_W'(1);
        end
    end

    // Remainder takes the dividend's sign; quotient and product take the XOR of both.
    always_comb begin
        prod   = neg_q ? -acc : acc;
        quo    = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem    = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        result = '0;
        if (fix) begin
            case (op)
                F3_MUL:                        result = prod[XLEN-1:0];
                F3_MULH, F3_MULHSU, F3_MULHU:  result = prod[2*XLEN-1:XLEN];
                F3_DIV, F3_DIVU:               result = quo;
                F3_REM, F3_REMU:               result = rem;
                default:                       result = '0;
            endcase
        end
    end

    assign last = (count == '0);

endmodule

// File: rtl/alu_pipe.sv
// Handshaked execute ALU: single-cycle base RV32I/RV64I ops and divide special
// cases, iterative M-extension ops through alu_muldiv_iter, abortable by kill.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic            aluneg,
    input  logic            muldiv,
    input  logic [XLEN-1:0] d1,
    input  logic [XLEN-1:0] d2,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);
    alu_state_t        state;
    alu_state_t        state_next;
    logic              accept;
    logic              div_zero;
    logic              div_ovf;
    logic              fast;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]   alu_out;
    logic [XLEN-1:0]   special_out;
    logic [XLEN-1:0]   fast_result;
    logic              md_start;
    logic              md_step;
    logic              md_fix;
    logic              md_last;
    logic [XLEN-1:0]   md_result;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready && !kill;

    always_comb begin
        shamt   = d2[SHAMT_W-1:0];
        alu_out = '0;
        case (funct3)
            F3_ADD:  alu_out = aluneg ? d1 - d2 : d1 + d2;
            F3_SLL:  alu_out = d1 << shamt;
            F3_SLT:  alu_out = {{(XLEN-1){1'b0}}, $signed(d1) < $signed(d2)};
            F3_SLTU: alu_out = {{(XLEN-1){1'b0}}, d1 < d2};
            F3_XOR:  alu_out = d1 ^ d2;
            F3_SRL:  alu_out = aluneg ? $unsigned($signed(d1) >>> shamt) : d1 >> shamt;
            F3_OR:   alu_out = d1 | d2;
            F3_AND:  alu_out = d1 & d2;
            default: alu_out = '0;
        endcase
    end

    // Divide by zero and signed overflow resolve immediately without iterating.
    always_comb begin
        div_zero    = (d2 == '0);
        div_ovf     = is_signed_a(funct3) && (d1 == {1'b1, {(XLEN-1){1'b0}}}) && (d2 == '1);
        fast        = !muldiv || (is_div(funct3) && (div_zero || div_ovf));
        if (is_rem(funct3))
            special_out = div_zero ? d1 : '0;
        else
            special_out = div_zero ? '1 : d1;
        fast_result = muldiv ? special_out : alu_out;
    end

    always_comb begin
        state_next = state;
        md_start   = 1'b0;
        md_step    = 1'b0;
        md_fix     = 1'b0;
        if (kill) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (fast) begin
                            state_next = DONE;
                        end else begin
                            state_next = BUSY;
                            md_start   = 1'b1;
                        end
                    end
                end
                BUSY: begin
                    md_step = 1'b1;
                    if (md_last)
                        state_next = FIX;
                end
                FIX: begin
                    md_fix     = 1'b1;
                    state_next = DONE;
                end
                DONE: begin
                    if (out_ready)
                        state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            result <= '0;
        end else begin
            state <= state_next;
            if (accept && fast)
                result <= fast_result;
            else if (md_fix)
                result <= md_result;
        end
    end

    alu_muldiv_iter #(
        .XLEN (XLEN)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .step   (md_step),
        .fix    (md_fix),
        .funct3 (funct3),
        .d1     (d1),
        .d2     (d2),
        .last   (md_last),
        .result (md_result)
    );

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: vector table through a result scoreboard,
// plus backpressure, kill, async reset and an XLEN=64 instance.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int IT32 = 33;
    localparam int IT64 = 65;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic        neg;
        logic        md;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, aluneg, muldiv, kill, out_valid, out_ready;
    logic [2:0]  funct3;
    logic [31:0] d1, d2, result;

    logic        v_in_valid, v_in_ready, v_aluneg, v_muldiv, v_kill, v_out_valid, v_out_ready;
    logic [2:0]  v_funct3;
    logic [63:0] v_d1, v_d2, v_result;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    string       cur_name = "";
    vec_t        vecs[$];

    always #5 clk = ~clk;

    alu_pipe #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .aluneg(aluneg), .muldiv(muldiv), .d1(d1), .d2(d2),
        .kill(kill), .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    alu_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(v_in_valid), .in_ready(v_in_ready),
        .funct3(v_funct3), .aluneg(v_aluneg), .muldiv(v_muldiv), .d1(v_d1), .d2(v_d2),
        .kill(v_kill), .out_valid(v_out_valid), .out_ready(v_out_ready), .result(v_result)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every output handshake pops the oldest expected result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output %s: got 0x%0h, expected no output", cur_name, result);
            end else begin
                mon_exp = exp_q.pop_front();
                check({"result ", cur_name}, result, mon_exp);
            end
        end
    end

    task automatic send(input logic [2:0] f3, input logic neg, input logic md,
                        input logic [31:0] a, input logic [31:0] b);
        int w;
        @(negedge clk);
        funct3 = f3; aluneg = neg; muldiv = md; d1 = a; d2 = b; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check({"in_ready_before_accept ", cur_name}, in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Latency is counted in rising edges after the accepting edge.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        cur_name = v.name;
        exp_q.push_back(v.exp);
        send(v.f3, v.neg, v.md, v.a, v.b);
        wait_valid(lat);
        check({"latency ", v.name}, lat, v.lat);
        @(posedge clk);
        #1;
        check({"in_ready_after ", v.name}, in_ready, 1);
        check({"out_valid_after ", v.name}, out_valid, 0);
    endtask

    task automatic run64(input string name, input logic [2:0] f3, input logic neg, input logic md,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        v_funct3 = f3; v_aluneg = neg; v_muldiv = md; v_d1 = a; v_d2 = b; v_in_valid = 1'b1;
        check({"v64_in_ready ", name}, v_in_ready, 1);
        @(posedge clk);
        #1 v_in_valid = 1'b0;
        lat = 0;
        while (!v_out_valid && lat < 200) begin
            @(posedge clk);
            #1 lat++;
        end
        check({"v64_latency ", name}, lat, exp_lat);
        check({"v64_result ", name}, v_result, exp);
        @(posedge clk);
        #1 check({"v64_in_ready_after ", name}, v_in_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic seen;

        rst = 1'b1; in_valid = 1'b0; funct3 = '0; aluneg = 1'b0; muldiv = 1'b0;
        d1 = '0; d2 = '0; kill = 1'b0; out_ready = 1'b1;
        v_in_valid = 1'b0; v_funct3 = '0; v_aluneg = 1'b0; v_muldiv = 1'b0;
        v_d1 = '0; v_d2 = '0; v_kill = 1'b0; v_out_ready = 1'b1;

        vecs.push_back('{"sub_5_7",      F3_ADD,    1'b1, 1'b0, 32'd5,        32'd7,        32'hFFFF_FFFE, 0});
        vecs.push_back('{"slt_m1_1",     F3_SLT,    1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,       32'd1,         0});
        vecs.push_back('{"sltu_max_1",   F3_SLTU,   1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,       32'd0,         0});
        vecs.push_back('{"sra_by4",      F3_SRL,    1'b1, 1'b0, 32'h8000_0000, 32'd4,       32'hF800_0000, 0});
        vecs.push_back('{"srl_by4",      F3_SRL,    1'b0, 1'b0, 32'h8000_0000, 32'd4,       32'h0800_0000, 0});
        vecs.push_back('{"sll_by33",     F3_SLL,    1'b0, 1'b0, 32'h1234_5678, 32'd33,      32'h2468_ACF0, 0});
        vecs.push_back('{"xor",          F3_XOR,    1'b0, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 0});
        vecs.push_back('{"or",           F3_OR,     1'b0, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 0});
        vecs.push_back('{"and_neg_ign",  F3_AND,    1'b1, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 0});
        vecs.push_back('{"mulh_min_min", F3_MULH,   1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, IT32});
        vecs.push_back('{"mulhsu_m1",    F3_MULHSU, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, IT32});
        vecs.push_back('{"mulhu_max",    F3_MULHU,  1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, IT32});
        vecs.push_back('{"mul_7_m3",     F3_MUL,    1'b0, 1'b1, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, IT32});
        vecs.push_back('{"div_7_m2",     F3_DIV,    1'b0, 1'b1, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, IT32});
        vecs.push_back('{"rem_7_m2",     F3_REM,    1'b0, 1'b1, 32'd7,        32'hFFFF_FFFE, 32'd1,         IT32});
        vecs.push_back('{"div_m7_2",     F3_DIV,    1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFD, IT32});
        vecs.push_back('{"rem_m7_2",     F3_REM,    1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF, IT32});
        vecs.push_back('{"divu_100_7",   F3_DIVU,   1'b0, 1'b1, 32'd100,      32'd7,        32'd14,        IT32});
        vecs.push_back('{"remu_100_7",   F3_REMU,   1'b0, 1'b1, 32'd100,      32'd7,        32'd2,         IT32});
        vecs.push_back('{"divu_by0",     F3_DIVU,   1'b0, 1'b1, 32'd100,      32'd0,        32'hFFFF_FFFF, 0});
        vecs.push_back('{"remu_by0",     F3_REMU,   1'b0, 1'b1, 32'd100,      32'd0,        32'd100,       0});
        vecs.push_back('{"div_m5_by0",   F3_DIV,    1'b0, 1'b1, 32'hFFFF_FFFB, 32'd0,       32'hFFFF_FFFF, 0});
        vecs.push_back('{"rem_m5_by0",   F3_REM,    1'b0, 1'b1, 32'hFFFF_FFFB, 32'd0,       32'hFFFF_FFFB, 0});
        vecs.push_back('{"div_ovf",      F3_DIV,    1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0});
        vecs.push_back('{"rem_ovf",      F3_REM,    1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        0});

        #12;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_result", result, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            run_vec(vecs[i]);

        // Backpressure: result held and in_ready low while the consumer stalls.
        cur_name = "bp_add";
        out_ready = 1'b0;
        exp_q.push_back(32'd7);
        send(F3_ADD, 1'b0, 1'b0, 32'd3, 32'd4);
        wait_valid(lat);
        check("bp_latency", lat, 0);
        repeat (10) begin
            @(posedge clk);
            #1;
            check("bp_result_stable", result, 7);
            check("bp_in_ready_low", in_ready, 0);
            check("bp_out_valid_held", out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_in_ready_after", in_ready, 1);
        check("bp_out_valid_after", out_valid, 0);

        // Kill in the 12th BUSY cycle of a DIVU, with a competing ADD presented.
        cur_name = "kill_divu";
        send(F3_DIVU, 1'b0, 1'b1, 32'd1000, 32'd3);
        repeat (11) @(posedge clk);
        #1;
        check("kill_busy_in_ready", in_ready, 0);
        kill = 1'b1; in_valid = 1'b1; funct3 = F3_ADD; aluneg = 1'b0; muldiv = 1'b0;
        d1 = 32'd9; d2 = 32'd9;
        @(posedge clk);
        #1 kill = 1'b0; in_valid = 1'b0;
        check("kill_in_ready", in_ready, 1);
        check("kill_out_valid", out_valid, 0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1 if (out_valid) seen = 1'b1;
        end
        check("kill_no_output", seen, 0);
        run_vec('{"add_1_1", F3_ADD, 1'b0, 1'b0, 32'd1, 32'd1, 32'd2, 0});

        // Asynchronous reset in the middle of a MUL.
        cur_name = "rst_mul";
        send(F3_MUL, 1'b0, 1'b1, 32'd3, 32'd5);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_in_ready", in_ready, 1);
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_result", result, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1 if (out_valid) seen = 1'b1;
        end
        check("rst_no_output", seen, 0);
        run_vec('{"mul_6_7", F3_MUL, 1'b0, 1'b1, 32'd6, 32'd7, 32'd42, IT32});

        run64("mulhu_max", F3_MULHU, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFE, IT64);
        run64("sra_by68", F3_SRL, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'd68,
              64'hF800_0000_0000_0000, 0);
        run64("div_m9_2", F3_DIV, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF7, 64'd2,
              64'hFFFF_FFFF_FFFF_FFFC, IT64);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
